// File: rtl/dcache_tag_lookup.sv
// Tag lookup / refill controller for the DCACHE_TAG simple-dual-port RAM.
// Sweeps the RAM invalid after reset, then serves lookups, invalidates and line fills.
module dcache_tag_lookup #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 9,
   parameter int OFF_W  = 3,
   parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_inv,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic              fill_req_valid,
   output logic [ADDR_W-1:0] fill_req_addr,
   input  logic              fill_ack,
   output logic              tag_wr_en,
   output logic [IDX_W-1:0]  tag_wr_addr,
   output logic [TAG_W:0]    tag_wr_data,
   output logic [IDX_W-1:0]  tag_rd_addr,
   input  logic [TAG_W:0]    tag_rd_data,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_CMP,
      S_MISS,
      S_UPD
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [TAG_W-1:0]    tag_q;
   logic                inv_q;
   logic                wr_en_q;
   logic [IDX_W-1:0]    wr_addr_q;
   logic [TAG_W:0]      wr_data_q;
   logic                fill_valid_q;
   logic [ADDR_W-1:0]   fill_addr_q;
   logic [15:0]         hit_cnt_q;
   logic [15:0]         miss_cnt_q;

   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                match;

   assign req_idx = req_addr[OFF_W+IDX_W-1:OFF_W];
   assign req_tag = req_addr[ADDR_W-1:OFF_W+IDX_W];
   assign match   = tag_rd_data[TAG_W] && (tag_rd_data[TAG_W-1:0] == tag_q);

   // Response depends on the RAM data of the compare cycle, so it is decoded from state.
   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = ((state_q == S_CMP) && (inv_q || match)) ||
                        ((state_q == S_UPD) && !inv_q);
   assign rsp_hit     = (state_q == S_CMP) && match;
   assign tag_rd_addr = (state_q == S_IDLE) ? req_idx : idx_q;

   assign tag_wr_en      = wr_en_q;
   assign tag_wr_addr    = wr_addr_q;
   assign tag_wr_data    = wr_data_q;
   assign fill_req_valid = fill_valid_q;
   assign fill_req_addr  = fill_addr_q;
   assign hit_cnt        = hit_cnt_q;
   assign miss_cnt       = miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         cnt_q        <= '0;
         idx_q        <= '0;
         tag_q        <= '0;
         inv_q        <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         case (state_q)
            S_INIT: begin
               // Leave once the write of the last entry has been presented for a cycle.
               if (wr_en_q && (wr_addr_q == '1)) begin
                  wr_en_q <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cnt_q;
                  wr_data_q <= '0;
                  cnt_q     <= cnt_q + IDX_W'(1);
               end
            end
            S_IDLE: begin
               if (req_valid) begin
                  idx_q   <= req_idx;
                  tag_q   <= req_tag;
                  inv_q   <= req_inv;
                  state_q <= S_CMP;
               end
            end
            S_CMP: begin
               if (inv_q) begin
                  if (match) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= idx_q;
                     wr_data_q <= {1'b0, tag_q};
                     state_q   <= S_UPD;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (match) begin
                  if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                  state_q <= S_IDLE;
               end else begin
                  if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                  fill_valid_q <= 1'b1;
                  fill_addr_q  <= {tag_q, idx_q, {OFF_W{1'b0}}};
                  state_q      <= S_MISS;
               end
            end
            S_MISS: begin
               if (fill_ack) begin
                  fill_valid_q <= 1'b0;
                  wr_en_q      <= 1'b1;
                  wr_addr_q    <= idx_q;
                  wr_data_q    <= {1'b1, tag_q};
                  state_q      <= S_UPD;
               end
            end
            S_UPD: begin
               wr_en_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_tag_lookup.sv
// Directed bench for dcache_tag_lookup with a behavioural 512 x 21 tag RAM
// (registered read address, write visible to reads sampled on later edges).
module tb_dcache_tag_lookup;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_inv = 1'b0;
   logic        rsp_valid;
   logic        rsp_hit;
   logic        fill_req_valid;
   logic [31:0] fill_req_addr;
   logic        fill_ack = 1'b0;
   logic        tag_wr_en;
   logic [8:0]  tag_wr_addr;
   logic [20:0] tag_wr_data;
   logic [8:0]  tag_rd_addr;
   logic [20:0] tag_rd_data;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int errors = 0;
   int checks = 0;

   logic [20:0] mem [512];
   logic [8:0]  rd_addr_q;

   always #5 clk = ~clk;

   // Tag RAM; while rst is held it is filled with valid entries of tag 1 so a missing sweep shows up as a false hit.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 512; i++) mem[i] <= 21'h100001;
      end else if (tag_wr_en) begin
         mem[tag_wr_addr] <= tag_wr_data;
      end
      rd_addr_q <= tag_rd_addr;
   end
   assign tag_rd_data = mem[rd_addr_q];

   dcache_tag_lookup #(.ADDR_W(32), .IDX_W(9), .OFF_W(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_inv        (req_inv),
      .rsp_valid      (rsp_valid),
      .rsp_hit        (rsp_hit),
      .fill_req_valid (fill_req_valid),
      .fill_req_addr  (fill_req_addr),
      .fill_ack       (fill_ack),
      .tag_wr_en      (tag_wr_en),
      .tag_wr_addr    (tag_wr_addr),
      .tag_wr_data    (tag_wr_data),
      .tag_rd_addr    (tag_rd_addr),
      .tag_rd_data    (tag_rd_data),
      .hit_cnt        (hit_cnt),
      .miss_cnt       (miss_cnt)
   );

   // Called at a falling edge; waits (bounded) for req_ready, presents one request,
   // and returns at the falling edge of the compare cycle.
   task automatic issue(input logic [31:0] addr, input logic inv, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b1;
      req_addr  = addr;
      req_inv   = inv;
      @(negedge clk);
      req_valid = 1'b0;
      req_inv   = 1'b0;
   endtask

   // Waits (bounded) for fill_req_valid, pulses fill_ack for one edge, returns in the UPD cycle.
   task automatic ack_fill(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (fill_req_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      fill_ack = 1'b1;
      @(negedge clk);
      fill_ack = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_hit !== 1'b0) begin errors++; $display("FAIL reset_rsp_hit: got %b want 0", rsp_hit); end
      checks++; if (fill_req_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_valid: got %b want 0", fill_req_valid); end
      checks++; if (fill_req_addr !== 32'h0) begin errors++; $display("FAIL reset_fill_addr: got %h want 0", fill_req_addr); end
      checks++; if ({tag_wr_en, tag_wr_addr, tag_wr_data} !== 31'h0) begin
         errors++; $display("FAIL reset_wr_port: got en=%b addr=%h data=%h want all 0", tag_wr_en, tag_wr_addr, tag_wr_data);
      end
      checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin
         errors++; $display("FAIL reset_counters: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
      end
   endtask

   // Releases reset at a falling edge and follows the sweep until req_ready rises.
   task automatic test_init_sweep(input string name);
      int nwr;
      int bad;
      int first_wr;
      int ready_cyc;
      nwr = 0; bad = 0; first_wr = -1; ready_cyc = -1;
      rst = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (tag_wr_en === 1'b1) begin
            if (first_wr < 0) first_wr = c;
            if (tag_wr_addr !== nwr[8:0] || tag_wr_data !== 21'h0 || req_ready !== 1'b0) bad++;
            nwr++;
         end else if (req_ready === 1'b1) begin
            ready_cyc = c;
            break;
         end
      end
      checks++; if (nwr != 512) begin errors++; $display("FAIL %s_write_count: got %0d want 512", name, nwr); end
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_write_content: got %0d bad writes want 0", name, bad); end
      checks++; if (first_wr != 0) begin errors++; $display("FAIL %s_first_write: got cycle %0d want 0", name, first_wr); end
      checks++; if (ready_cyc != 512) begin errors++; $display("FAIL %s_ready_cycle: got %0d want 512", name, ready_cyc); end
      checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin
         errors++; $display("FAIL %s_counters: got hit=%0d miss=%0d want 0/0", name, hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_miss_fill;
      bit ok;
      int bad;
      issue(32'h0000_1008, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_accept_timeout: got %b want 1", ok); end
      checks++; if ({rsp_valid, fill_req_valid} !== 2'b00) begin
         errors++; $display("FAIL miss_cmp_cycle: got rsp_valid=%b fill_valid=%b want 0/0", rsp_valid, fill_req_valid);
      end
      @(negedge clk);
      checks++; if (fill_req_valid !== 1'b1) begin errors++; $display("FAIL miss_fill_valid: got %b want 1", fill_req_valid); end
      checks++; if (fill_req_addr !== 32'h0000_1008) begin errors++; $display("FAIL miss_fill_addr: got %h want 00001008", fill_req_addr); end
      checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt_1: got %0d want 1", miss_cnt); end
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (fill_req_valid !== 1'b1 || fill_req_addr !== 32'h0000_1008 || tag_wr_en !== 1'b0 || req_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL miss_hold: got %0d unstable cycles want 0", bad); end
      ack_fill(ok);
      checks++; if (tag_wr_en !== 1'b1 || tag_wr_addr !== 9'h001 || tag_wr_data !== 21'h100001) begin
         errors++; $display("FAIL miss_upd_write: got en=%b addr=%h data=%h want 1/001/100001", tag_wr_en, tag_wr_addr, tag_wr_data);
      end
      checks++; if ({rsp_valid, rsp_hit, fill_req_valid, req_ready} !== 4'b1000) begin
         errors++; $display("FAIL miss_upd_rsp: got valid=%b hit=%b fill=%b ready=%b want 1/0/0/0", rsp_valid, rsp_hit, fill_req_valid, req_ready);
      end
      @(negedge clk);
      checks++; if ({req_ready, tag_wr_en, rsp_valid} !== 3'b100) begin
         errors++; $display("FAIL miss_after_upd: got ready=%b wr=%b rsp=%b want 1/0/0", req_ready, tag_wr_en, rsp_valid);
      end
   endtask

   task automatic test_hit;
      bit ok;
      issue(32'h0000_100C, 1'b0, ok);
      checks++; if ({rsp_valid, rsp_hit, tag_wr_en, req_ready} !== 4'b1100) begin
         errors++; $display("FAIL hit_rsp: got valid=%b hit=%b wr=%b ready=%b want 1/1/0/0", rsp_valid, rsp_hit, tag_wr_en, req_ready);
      end
      @(negedge clk);
      checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
         errors++; $display("FAIL hit_counters: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
      end
      checks++; if ({req_ready, rsp_valid, tag_wr_en, fill_req_valid} !== 4'b1000) begin
         errors++; $display("FAIL hit_after: got ready=%b rsp=%b wr=%b fill=%b want 1/0/0/0", req_ready, rsp_valid, tag_wr_en, fill_req_valid);
      end
   endtask

   task automatic test_fill_ack_ignored;
      fill_ack = 1'b1;
      @(negedge clk);
      fill_ack = 1'b0;
      checks++; if ({req_ready, tag_wr_en, fill_req_valid, rsp_valid} !== 4'b1000) begin
         errors++; $display("FAIL ack_in_idle: got ready=%b wr=%b fill=%b rsp=%b want 1/0/0/0", req_ready, tag_wr_en, fill_req_valid, rsp_valid);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      issue(32'h0000_3008, 1'b0, ok);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_miss3_rsp: got %b want 0", rsp_valid); end
      ack_fill(ok);
      checks++; if (ok !== 1'b1 || tag_wr_addr !== 9'h001 || tag_wr_data !== 21'h100003 || tag_wr_en !== 1'b1) begin
         errors++; $display("FAIL b2b_miss3_write: got ok=%b en=%b addr=%h data=%h want 1/1/001/100003", ok, tag_wr_en, tag_wr_addr, tag_wr_data);
      end
      @(negedge clk);
      // Same index issued in the first ready cycle after the update.
      issue(32'h0000_3008, 1'b0, ok);
      checks++; if ({rsp_valid, rsp_hit} !== 2'b11) begin
         errors++; $display("FAIL b2b_same_idx_hit: got valid=%b hit=%b want 1/1", rsp_valid, rsp_hit);
      end
      @(negedge clk);
      issue(32'h0000_1008, 1'b0, ok);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_old_tag_miss: got rsp_valid=%b want 0", rsp_valid); end
      ack_fill(ok);
      @(negedge clk);
      issue(32'h0000_3008, 1'b0, ok);
      ack_fill(ok);
      @(negedge clk);
      checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd4) begin
         errors++; $display("FAIL b2b_counters: got hit=%0d miss=%0d want 2/4", hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_invalidate;
      bit ok;
      issue(32'h0000_3008, 1'b1, ok);
      checks++; if ({rsp_valid, rsp_hit, tag_wr_en} !== 3'b110) begin
         errors++; $display("FAIL inv_hit_rsp: got valid=%b hit=%b wr=%b want 1/1/0", rsp_valid, rsp_hit, tag_wr_en);
      end
      @(negedge clk);
      checks++; if (tag_wr_en !== 1'b1 || tag_wr_addr !== 9'h001 || tag_wr_data !== 21'h000003 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++; $display("FAIL inv_write: got en=%b addr=%h data=%h rsp=%b ready=%b want 1/001/000003/0/0",
                            tag_wr_en, tag_wr_addr, tag_wr_data, rsp_valid, req_ready);
      end
      @(negedge clk);
      issue(32'h0000_3008, 1'b1, ok);
      checks++; if ({rsp_valid, rsp_hit} !== 2'b10) begin
         errors++; $display("FAIL inv_again_rsp: got valid=%b hit=%b want 1/0", rsp_valid, rsp_hit);
      end
      @(negedge clk);
      checks++; if ({tag_wr_en, req_ready} !== 2'b01) begin
         errors++; $display("FAIL inv_again_nowrite: got wr=%b ready=%b want 0/1", tag_wr_en, req_ready);
      end
      checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd4) begin
         errors++; $display("FAIL inv_counters: got hit=%0d miss=%0d want 2/4", hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_reset_in_miss;
      bit ok;
      issue(32'h0000_5008, 1'b0, ok);
      @(negedge clk);
      checks++; if (fill_req_valid !== 1'b1) begin errors++; $display("FAIL rstmiss_in_miss: got %b want 1", fill_req_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({fill_req_valid, req_ready, tag_wr_en, rsp_valid} !== 4'b0000 || fill_req_addr !== 32'h0) begin
         errors++; $display("FAIL rstmiss_async: got fill=%b addr=%h ready=%b wr=%b rsp=%b want all 0",
                            fill_req_valid, fill_req_addr, req_ready, tag_wr_en, rsp_valid);
      end
      checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin
         errors++; $display("FAIL rstmiss_counters: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
      end
      repeat (2) @(negedge clk);
      test_init_sweep("reinit");
      issue(32'h0000_1008, 1'b0, ok);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reinit_lookup_miss: got rsp_valid=%b want 0", rsp_valid); end
      @(negedge clk);
      checks++; if (fill_req_valid !== 1'b1 || miss_cnt !== 16'd1) begin
         errors++; $display("FAIL reinit_fill: got fill=%b miss=%0d want 1/1", fill_req_valid, miss_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_init_sweep("init");
      test_miss_fill();
      test_hit();
      test_fill_ack_ignored();
      test_back_to_back();
      test_invalidate();
      test_reset_in_miss();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
